alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-word operation sequencer. It is the initiator that drives the existing 8-bit ALU combinational ports: FuncOp, A, B, IFlags and OE in; Y and OFlags out.
- Accepts one wide command (op, A, B, initial flags) over a valid/ready handshake.
- Issues one ALU slice per clock, chaining each slice's OFlags into the next slice's IFlags.
- Assembles the wide result and final flags, then presents them on a valid/ready response port.
- Sits between the control unit and the ALU, so the datapath can perform 32-bit arithmetic and shifts on the 8-bit ALU.

Parameters:
BitWidth, 8, width of one ALU slice (must equal the ALU's BitWidth)
Words, 4, number of slices per operand; wide width W = BitWidth*Words; Words >= 1

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high
CmdValid  in  1  command offered
CmdReady  out  1  sequencer can accept
CmdOp  in  4  ALU FuncOp for every slice
CmdA  in  W  wide operand A
CmdB  in  W  wide operand B
CmdFlags  in  4  IFlags for first slice
CmdMsbFirst  in  1  1 = process slices MS->LS (right shifts), 0 = LS->MS
RspValid  out  1  result available
RspReady  in  1  consumer takes result
RspY  out  W  wide result
RspFlags  out  4  final flags {V,N,C,Z} = bits [3:0] = {3,2,1,0}
AluFuncOp  out  4  to ALU FuncOp
AluA  out  BitWidth  to ALU A
AluB  out  BitWidth  to ALU B
AluIFlags  out  4  to ALU IFlags
AluOE  out  1  to ALU OE
AluY  in  BitWidth  from ALU Y
AluOFlags  in  4  from ALU OFlags

Behaviour:
- Interface decision: one clock (Clock); Reset is synchronous and active-high. All state changes occur on the Clock rising edge.
- Reset values:
  - State IDLE, CmdReady=1, RspValid=0, RspY=0, RspFlags=0.
  - Slice index 0, AluOE=0.
  - AluFuncOp, AluA, AluB and AluIFlags all 0.
- States: IDLE, EXEC, DONE.
- IDLE:
  - CmdReady=1.
  - On CmdValid&&CmdReady, latch CmdOp, CmdA, CmdB, CmdFlags and CmdMsbFirst; set slice index to 0; set running Z=1; go to EXEC.
  - CmdReady=0 in every other state. Commands offered then are ignored, not queued.
- EXEC, one cycle per slice, s = 0..Words-1:
  - Physical slice p = s when MsbFirst=0, else Words-1-s.
  - Drive AluA = A[p], AluB = B[p] (BitWidth-bit slices), AluFuncOp = op, AluOE = 1.
  - AluIFlags = latched CmdFlags when s = 0, else the previous slice's captured OFlags.
  - At the edge ending the cycle: RspY slice p <= AluY; carry register <= AluOFlags; Z_run <= Z_run & AluOFlags[0].
  - If p = Words-1 (most-significant slice), also capture N and V from AluOFlags.
  - After s = Words-1, go to DONE.
- Alu* outputs are combinational from registered state. They are 0 and AluOE is 0 outside EXEC.
- Final flags:
  - Z = AND of all slice Z.
  - C = C of the last processed slice.
  - N and V come from the most-significant slice, regardless of processing order.
- Latency: command accepted at edge k, RspValid=1 from edge k+Words. The ALU is assumed to settle combinationally within one cycle.
- DONE:
  - RspValid=1; RspY and RspFlags held stable.
  - On RspValid&&RspReady go to IDLE and drop RspValid.
  - RspY and RspFlags keep their values until the next command overwrites them slice by slice.
- No overlap: the minimum command-to-command spacing is Words+2 cycles (accept, Words EXEC, DONE handshake).
- Words=1 degenerates to a single EXEC cycle. CmdFlags goes straight to AluIFlags.
- Reset in any state: next cycle IDLE. Any partial result is discarded, RspY and RspFlags are cleared, and AluOE drops.
- Reset asserted together with CmdValid: the command is not accepted.

Test Plan:
All scenarios use Words=4, BitWidth=8 and a real ALU instance; ADD, LSL and LSR refer to the team's ALU opcode values.

- ADD, A=0x00FFFFFF, B=0x00000001, CmdFlags=0:
  - AluIFlags carry (bit1) is 0 on slice 0 and 1 on slices 1, 2, 3.
  - RspY=0x01000000, RspFlags Z=0, C=0, N=0.
  - RspValid rises exactly 4 cycles after the accept edge.
- ADD wrap, A=0xFFFFFFFF, B=0x00000001 -> RspY=0x00000000, Z=1, C=1.
- LSL, A=0x80808080, MsbFirst=0, carry-in 0 -> RspY=0x01010100, C=1. LSR, A=0x01010101, MsbFirst=1 -> RspY=0x00808080, C=1; AluA sequence is 0x01 with slice 3 first.
- Backpressure: hold RspReady=0 for 5 cycles after RspValid.
  - RspY and RspFlags stay constant and CmdReady stays 0.
  - A CmdValid pulse offered during this window is ignored.
  - Raise RspReady: one cycle later RspValid=0, CmdReady=1.
- Reset asserted during the 2nd EXEC cycle of an ADD:
  - Next cycle IDLE, RspValid=0, RspY=0, AluOE=0.
  - A following ADD 0x00000002+0x00000003 returns 0x00000005, with no stale carry.
- Back-to-back: CmdValid held high with RspReady=1 for three commands -> three responses, each accepted Words+2=6 cycles apart.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Command/response bundle between the control unit (master) and the
// multi-word ALU sequencer (slave).
interface alu_sequencer_if #(
    parameter int BitWidth = 8,
    parameter int Words    = 4
);
    localparam int W = BitWidth * Words;

    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [3:0]   cmd_flags;
    logic         cmd_msb_first;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_y;
    logic [3:0]   rsp_flags;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_flags, cmd_msb_first, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_y, rsp_flags
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_flags, cmd_msb_first, rsp_ready,
        output cmd_ready, rsp_valid, rsp_y, rsp_flags
    );
endinterface

// File: rtl/alu_sequencer.sv
// Runs one wide command through a narrow combinational ALU, one slice per
// clock, chaining flags between slices and assembling the wide result.
module alu_sequencer #(
    parameter int BitWidth = 8,
    parameter int Words    = 4
) (
    input  logic                clk,
    input  logic                srst,
    alu_sequencer_if.slave      bus,
    output logic [3:0]          alu_func_op,
    output logic [BitWidth-1:0] alu_a,
    output logic [BitWidth-1:0] alu_b,
    output logic [3:0]          alu_iflags,
    output logic                alu_oe,
    input  logic [BitWidth-1:0] alu_y,
    input  logic [3:0]          alu_oflags
);
    localparam int W    = BitWidth * Words;
    localparam int IdxW = (Words > 1) ? $clog2(Words) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state_reg, state_next;
    logic [IdxW-1:0] slice_reg, slice_next;
    logic [3:0]      op_reg;
    logic            msb_first_reg;
    logic [W-1:0]    a_reg, b_reg;
    logic [3:0]      chain_flags_reg;
    logic            z_run_reg, n_reg, v_reg;
    logic [W-1:0]    rsp_y_bus;

    logic            accept;
    logic            exec_step;
    logic [IdxW-1:0] phys_idx;

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == DONE);
    assign accept        = bus.cmd_valid && (state_reg == IDLE);
    assign exec_step     = (state_reg == EXEC);
    assign phys_idx      = msb_first_reg ? (LastIdx - slice_reg) : slice_reg;

    always_comb begin
        state_next = state_reg;
        slice_next = slice_reg;
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_next = EXEC;
                    slice_next = '0;
                end
            end
            EXEC: begin
                if (slice_reg == LastIdx) begin
                    state_next = DONE;
                    slice_next = '0;
                end else begin
                    slice_next = slice_reg + 1'b1;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ALU drive is purely a function of registered state; quiet outside EXEC.
    always_comb begin
        alu_func_op = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_iflags  = '0;
        alu_oe      = 1'b0;
        if (exec_step) begin
            alu_func_op = op_reg;
            alu_a       = a_reg[int'(phys_idx) * BitWidth +: BitWidth];
            alu_b       = b_reg[int'(phys_idx) * BitWidth +: BitWidth];
            alu_iflags  = chain_flags_reg;
            alu_oe      = 1'b1;
        end
    end

    // chain_flags_reg holds CmdFlags for slice 0, then the previous slice's OFlags.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg       <= IDLE;
            slice_reg       <= '0;
            op_reg          <= '0;
            msb_first_reg   <= 1'b0;
            a_reg           <= '0;
            b_reg           <= '0;
            chain_flags_reg <= '0;
            z_run_reg       <= 1'b0;
            n_reg           <= 1'b0;
            v_reg           <= 1'b0;
        end else begin
            state_reg <= state_next;
            slice_reg <= slice_next;
            if (accept) begin
                op_reg          <= bus.cmd_op;
                msb_first_reg   <= bus.cmd_msb_first;
                a_reg           <= bus.cmd_a;
                b_reg           <= bus.cmd_b;
                chain_flags_reg <= bus.cmd_flags;
                z_run_reg       <= 1'b1;
            end
            if (exec_step) begin
                chain_flags_reg <= alu_oflags;
                z_run_reg       <= z_run_reg & alu_oflags[0];
                if (phys_idx == LastIdx) begin
                    n_reg <= alu_oflags[2];
                    v_reg <= alu_oflags[3];
                end
            end
        end
    end

    for (genvar gi = 0; gi < Words; gi++) begin : g_slice
        logic [BitWidth-1:0] y_word_reg;

        always_ff @(posedge clk) begin
            if (srst) begin
                y_word_reg <= '0;
            end else if (exec_step && (phys_idx == IdxW'(gi))) begin
                y_word_reg <= alu_y;
            end
        end

        assign rsp_y_bus[gi*BitWidth +: BitWidth] = y_word_reg;
    end

    assign bus.rsp_y     = rsp_y_bus;
    assign bus.rsp_flags = {v_reg, n_reg, chain_flags_reg[1], z_run_reg};
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer with an 8-bit ALU stand-in
// and a whole-word reference model.
module tb_alu_sequencer;
    localparam int BitWidth = 8;
    localparam int Words    = 4;
    localparam int W        = BitWidth * Words;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_LSL = 4'h8;
    localparam logic [3:0] OP_LSR = 4'h9;

    logic clk  = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    alu_sequencer_if #(.BitWidth(BitWidth), .Words(Words)) bus ();

    logic [3:0]          alu_func_op, alu_iflags, alu_oflags;
    logic [BitWidth-1:0] alu_a, alu_b, alu_y;
    logic                alu_oe;
    logic [BitWidth:0]   alu_sum;

    alu_sequencer #(.BitWidth(BitWidth), .Words(Words)) dut (
        .clk         (clk),
        .srst        (srst),
        .bus         (bus),
        .alu_func_op (alu_func_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_iflags  (alu_iflags),
        .alu_oe      (alu_oe),
        .alu_y       (alu_y),
        .alu_oflags  (alu_oflags)
    );

    // 8-bit ALU stand-in; flags {V,N,C,Z}, carry taken from IFlags[1].
    always_comb begin
        alu_sum       = '0;
        alu_y         = alu_a;
        alu_oflags    = 4'b0;
        alu_oflags[1] = alu_iflags[1];
        case (alu_func_op)
            OP_ADD: begin
                alu_sum       = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_iflags[1]);
                alu_y         = alu_sum[7:0];
                alu_oflags[1] = alu_sum[8];
                alu_oflags[3] = (alu_a[7] == alu_b[7]) && (alu_sum[7] != alu_a[7]);
            end
            OP_AND: alu_y = alu_a & alu_b;
            OP_LSL: begin
                alu_y         = {alu_a[6:0], alu_iflags[1]};
                alu_oflags[1] = alu_a[7];
            end
            OP_LSR: begin
                alu_y         = {alu_iflags[1], alu_a[7:1]};
                alu_oflags[1] = alu_a[0];
            end
            default: ;
        endcase
        alu_oflags[2] = alu_y[7];
        alu_oflags[0] = (alu_y == 8'h00);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-word result of the operation, independent of slicing.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] fl, output logic [W-1:0] y, output logic [3:0] f);
        logic [W:0] s;
        logic c, v;
        c = fl[1];
        v = 1'b0;
        y = a;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b} + (W+1)'(fl[1]);
                y = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
            end
            OP_AND: y = a & b;
            OP_LSL: begin
                y = {a[W-2:0], fl[1]};
                c = a[W-1];
            end
            OP_LSR: begin
                y = {fl[1], a[W-1:1]};
                c = a[0];
            end
            default: ;
        endcase
        f = {v, y[W-1], c, (y == '0)};
    endfunction

    logic [BitWidth-1:0] tr_a  [Words];
    logic [BitWidth-1:0] tr_b  [Words];
    logic [3:0]          tr_if [Words];
    logic                tr_oe [Words];

    // Called at a negedge in IDLE; returns at the negedge where RspValid must be 1.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] fl, input logic msb);
        check("cmd_ready_idle", bus.cmd_ready, 1'b1);
        bus.cmd_valid     = 1'b1;
        bus.cmd_op        = op;
        bus.cmd_a         = a;
        bus.cmd_b         = b;
        bus.cmd_flags     = fl;
        bus.cmd_msb_first = msb;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        for (int s = 0; s < Words; s++) begin
            @(negedge clk);
            tr_a[s]  = alu_a;
            tr_b[s]  = alu_b;
            tr_if[s] = alu_iflags;
            tr_oe[s] = alu_oe;
            check("rsp_valid_exec", bus.rsp_valid, 1'b0);
        end
        @(negedge clk);
        check("rsp_latency", bus.rsp_valid, 1'b1);
    endtask

    task automatic release_rsp(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rsp_valid_hold", bus.rsp_valid, 1'b1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_valid_drop", bus.rsp_valid, 1'b0);
        check("cmd_ready_back", bus.cmd_ready, 1'b1);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] fl, input logic msb, input int hold,
                           output logic [W-1:0] got_y, output logic [3:0] got_f);
        logic [W-1:0] ey;
        logic [3:0]   ef;
        int p;
        model(op, a, b, fl, ey, ef);
        issue(op, a, b, fl, msb);
        for (int s = 0; s < Words; s++) begin
            p = msb ? (Words - 1 - s) : s;
            check("alu_a_order", tr_a[s], a[p*BitWidth +: BitWidth]);
            check("alu_b_order", tr_b[s], b[p*BitWidth +: BitWidth]);
            check("alu_oe_exec", tr_oe[s], 1'b1);
        end
        check("alu_iflags_first", tr_if[0], fl);
        got_y = bus.rsp_y;
        got_f = bus.rsp_flags;
        check("rsp_y", got_y, ey);
        check("rsp_flags", got_f, ef);
        $display("cmd op=%h a=%h b=%h fl=%h msb=%0d -> y=%h flags=%h", op, a, b, fl, msb, got_y, got_f);
        release_rsp(hold);
    endtask

    initial begin
        logic [W-1:0] y, a, b, ey, hold_y;
        logic [3:0]   f, fl, op, ef, hold_f;
        logic         msb;
        logic [W-1:0] exp_q [$];
        int acc_cyc [$];
        int k, rk;
        logic accepted;

        bus.cmd_valid     = 1'b1;
        bus.cmd_op        = OP_ADD;
        bus.cmd_a         = 32'h1234_5678;
        bus.cmd_b         = 32'h1;
        bus.cmd_flags     = 4'h0;
        bus.cmd_msb_first = 1'b0;
        bus.rsp_ready     = 1'b0;

        // Reset while a command is offered: it must not be taken.
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", bus.cmd_ready, 1'b1);
        check("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check("reset_rsp_y", bus.rsp_y, 32'h0);
        check("reset_rsp_flags", bus.rsp_flags, 4'h0);
        check("reset_alu_oe", alu_oe, 1'b0);
        check("reset_alu_drive", {alu_func_op, alu_a, alu_b, alu_iflags}, 24'h0);
        srst          = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("reset_no_accept_oe", alu_oe, 1'b0);
        check("reset_no_accept_ready", bus.cmd_ready, 1'b1);

        // Carry ripple across slices.
        run_cmd(OP_ADD, 32'h00FF_FFFF, 32'h0000_0001, 4'h0, 1'b0, 0, y, f);
        for (int s = 0; s < Words; s++)
            check("add_carry_chain", tr_if[s][1], (s == 0) ? 1'b0 : 1'b1);
        check("add_y_const", y, 32'h0100_0000);
        check("add_flags_const", f, 4'h0);

        run_cmd(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 4'h0, 1'b0, 1, y, f);
        check("wrap_y_const", y, 32'h0);
        check("wrap_zc_const", f[1:0], 2'b11);

        run_cmd(OP_LSL, 32'h8080_8080, 32'h0, 4'h0, 1'b0, 0, y, f);
        check("lsl_y_const", y, 32'h0101_0100);
        check("lsl_c_const", f[1], 1'b1);

        run_cmd(OP_LSR, 32'h0101_0101, 32'h0, 4'h0, 1'b1, 0, y, f);
        check("lsr_y_const", y, 32'h0080_8080);
        check("lsr_c_const", f[1], 1'b1);

        // Backpressure with a stray command offered while DONE.
        a = $urandom;
        b = $urandom;
        model(OP_ADD, a, b, 4'h0, ey, ef);
        issue(OP_ADD, a, b, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", bus.rsp_valid, 1'b1);
            check("bp_rsp_y", bus.rsp_y, ey);
            check("bp_rsp_flags", bus.rsp_flags, ef);
            check("bp_cmd_ready", bus.cmd_ready, 1'b0);
            bus.cmd_valid = (i == 2);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        $display("backpressure a=%h b=%h y=%h", a, b, bus.rsp_y);
        release_rsp(0);
        for (int i = 0; i < Words + 2; i++) begin
            check("stray_cmd_ignored", {bus.rsp_valid, alu_oe}, 2'b00);
            @(negedge clk);
        end

        // Reset in the second EXEC cycle.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ADD;
        bus.cmd_a     = 32'hFFFF_FFFF;
        bus.cmd_b     = 32'h0000_0001;
        bus.cmd_flags = 4'h0;
        bus.cmd_msb_first = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_exec_oe", alu_oe, 1'b1);
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        @(negedge clk);
        check("midrst_cmd_ready", bus.cmd_ready, 1'b1);
        check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        check("midrst_rsp_y", bus.rsp_y, 32'h0);
        check("midrst_rsp_flags", bus.rsp_flags, 4'h0);
        check("midrst_alu_oe", alu_oe, 1'b0);
        $display("reset during exec");
        run_cmd(OP_ADD, 32'h2, 32'h3, 4'h0, 1'b0, 0, y, f);
        check("post_reset_add", y, 32'h5);

        // Back-to-back commands with CmdValid and RspReady held high.
        k  = 0;
        rk = 0;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            model(OP_ADD, a, b, 4'h0, ey, ef);
            exp_q.push_back(ey);
            exp_q.push_back(a);
            exp_q.push_back(b);
        end
        bus.cmd_op        = OP_ADD;
        bus.cmd_flags     = 4'h0;
        bus.cmd_msb_first = 1'b0;
        bus.cmd_a         = exp_q[1];
        bus.cmd_b         = exp_q[2];
        bus.cmd_valid     = 1'b1;
        bus.rsp_ready     = 1'b1;
        for (int c = 0; c < 60 && rk < 3; c++) begin
            accepted = 1'b0;
            if (bus.rsp_valid) begin
                check("b2b_rsp_y", bus.rsp_y, exp_q[3*rk]);
                $display("b2b rsp %0d y=%h cycle=%0d", rk, bus.rsp_y, c);
                rk++;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cyc.push_back(c);
                accepted = 1'b1;
                k++;
            end
            @(posedge clk);
            #1;
            if (accepted) begin
                if (k < 3) begin
                    bus.cmd_a = exp_q[3*k+1];
                    bus.cmd_b = exp_q[3*k+2];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check("b2b_rsp_count", rk, 3);
        check("b2b_acc_count", acc_cyc.size(), 3);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], Words + 2);
        @(negedge clk);

        // Randomized commands against the whole-word model.
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0: begin op = OP_ADD; msb = 1'b0; end
                1: begin op = OP_LSL; msb = 1'b0; end
                2: begin op = OP_LSR; msb = 1'b1; end
                default: begin op = OP_AND; msb = 1'($urandom_range(0, 1)); end
            endcase
            a  = $urandom;
            b  = $urandom;
            fl = 4'($urandom_range(0, 15));
            if ((i % 5) == 0) b = ~a;
            run_cmd(op, a, b, fl, msb, $urandom_range(0, 2), y, f);
        end

        hold_y = y;
        hold_f = f;
        repeat (2) @(negedge clk);
        check("idle_rsp_y_kept", bus.rsp_y, hold_y);
        check("idle_rsp_flags_kept", bus.rsp_flags, hold_f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
